// File: rtl/hdmi_link_ctrl_if.sv
// Control/status bundle between hdmi_link_ctrl and its surroundings: HPD pin, PLL lock,
// vsync from hdmi_driver, and the reset/enable/status outputs.
interface hdmi_link_ctrl_if;
  logic        hpd;
  logic        pll_locked;
  logic        vsync;
  logic        tx_rst;
  logic        tx_en;
  logic        link_up;
  logic        fault;
  logic [2:0]  state;
  logic [15:0] frame_cnt;
  logic [7:0]  fault_cnt;

  modport master (
    output hpd, pll_locked, vsync,
    input  tx_rst, tx_en, link_up, fault, state, frame_cnt, fault_cnt
  );

  modport slave (
    input  hpd, pll_locked, vsync,
    output tx_rst, tx_en, link_up, fault, state, frame_cnt, fault_cnt
  );
endinterface

// File: rtl/hdmi_link_ctrl.sv
// Bring-up and supervision FSM for the TMDS transmitter: debounced HPD, PLL lock, vsync watchdog.
// Define LINK_STATS_EN to build the frame/fault statistics counters.
module hdmi_link_ctrl #(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int SETTLE_CYCLES   = 1024,
  parameter int VSYNC_TIMEOUT   = 1000000,
  parameter int RETRY_CYCLES    = 25000,
  parameter int CNT_W           = 24
) (
  input  logic           clk,
  input  logic           rst,
  hdmi_link_ctrl_if.slave lnk
);

  // state | 0 WAIT_HPD | 1 WAIT_LOCK | 2 SETTLE | 3 WAIT_VSYNC | 4 RUN | 5 FAULT
  typedef enum logic [2:0] {
    S_WAIT_HPD   = 3'd0,
    S_WAIT_LOCK  = 3'd1,
    S_SETTLE     = 3'd2,
    S_WAIT_VSYNC = 3'd3,
    S_RUN        = 3'd4,
    S_FAULT      = 3'd5
  } state_t;

  localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);

  logic [1:0]       r_hpd_sync;
  logic [1:0]       r_lock_sync;
  logic [1:0]       r_vs_sync;
  logic             r_vs_prev;
  logic [DB_W-1:0]  r_db_cnt;
  logic             r_hpd_db;
  state_t           r_state;
  state_t           w_nxt;
  logic [CNT_W-1:0] r_timer;
  logic             r_tx_rst;
  logic             r_tx_en;
  logic             r_link_up;
  logic             r_fault;
  logic             w_vs_edge;
  logic             w_lock;
  logic             w_fault_entry;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_hpd_sync  <= '0;
      r_lock_sync <= '0;
      r_vs_sync   <= '0;
      r_vs_prev   <= 1'b0;
    end else begin
      r_hpd_sync  <= {r_hpd_sync[0], lnk.hpd};
      r_lock_sync <= {r_lock_sync[0], lnk.pll_locked};
      r_vs_sync   <= {r_vs_sync[0], lnk.vsync};
      r_vs_prev   <= r_vs_sync[1];
    end
  end

  assign w_vs_edge = r_vs_sync[1] & ~r_vs_prev;
  assign w_lock    = r_lock_sync[1];

  // Any sample agreeing with the accepted level restarts the debounce window.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_db_cnt <= '0;
      r_hpd_db <= 1'b0;
    end else if (r_hpd_sync[1] == r_hpd_db) begin
      r_db_cnt <= '0;
    end else if (r_db_cnt == DB_W'(DEBOUNCE_CYCLES - 1)) begin
      r_db_cnt <= '0;
      r_hpd_db <= r_hpd_sync[1];
    end else begin
      r_db_cnt <= r_db_cnt + 1'b1;
    end
  end

  always_comb begin
    w_nxt = r_state;
    case (r_state)
      S_FAULT: begin
        if (r_timer == CNT_W'(RETRY_CYCLES - 1)) w_nxt = S_WAIT_HPD;
      end
      S_WAIT_HPD: begin
        if (r_hpd_db) w_nxt = S_WAIT_LOCK;
      end
      S_WAIT_LOCK: begin
        if (!r_hpd_db)   w_nxt = S_WAIT_HPD;
        else if (w_lock) w_nxt = S_SETTLE;
      end
      S_SETTLE: begin
        if (!r_hpd_db)                                 w_nxt = S_WAIT_HPD;
        else if (!w_lock)                              w_nxt = S_WAIT_LOCK;
        else if (r_timer == CNT_W'(SETTLE_CYCLES - 1)) w_nxt = S_WAIT_VSYNC;
      end
      S_WAIT_VSYNC: begin
        if (!r_hpd_db)                                 w_nxt = S_WAIT_HPD;
        else if (!w_lock)                              w_nxt = S_FAULT;
        else if (w_vs_edge)                            w_nxt = S_RUN;
        else if (r_timer == CNT_W'(VSYNC_TIMEOUT - 1)) w_nxt = S_FAULT;
      end
      S_RUN: begin
        if (!r_hpd_db)                                 w_nxt = S_WAIT_HPD;
        else if (!w_lock)                              w_nxt = S_FAULT;
        else if (w_vs_edge)                            w_nxt = S_RUN;
        else if (r_timer == CNT_W'(VSYNC_TIMEOUT - 1)) w_nxt = S_FAULT;
      end
      default: w_nxt = S_WAIT_HPD;
    endcase
  end

  assign w_fault_entry = (w_nxt == S_FAULT) && (r_state != S_FAULT);

  // The idle states never exit on the timer, so it saturates instead of wrapping there.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_WAIT_HPD;
      r_timer   <= '0;
      r_tx_rst  <= 1'b1;
      r_tx_en   <= 1'b0;
      r_link_up <= 1'b0;
      r_fault   <= 1'b0;
    end else begin
      r_state <= w_nxt;
      if (w_nxt != r_state || (r_state == S_RUN && w_vs_edge))
        r_timer <= '0;
      else if (!(&r_timer))
        r_timer <= r_timer + 1'b1;
      r_fault   <= w_fault_entry;
      r_tx_rst  <= !(r_state == S_WAIT_VSYNC || r_state == S_RUN);
      r_tx_en   <= (r_state == S_RUN);
      r_link_up <= (r_state == S_RUN);
    end
  end

  assign lnk.tx_rst  = r_tx_rst;
  assign lnk.tx_en   = r_tx_en;
  assign lnk.link_up = r_link_up;
  assign lnk.fault   = r_fault;
  assign lnk.state   = r_state;

`ifdef LINK_STATS_EN
  logic [15:0] r_frame_cnt;
  logic [7:0]  r_fault_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_frame_cnt <= '0;
      r_fault_cnt <= '0;
    end else begin
      if (r_state == S_RUN && w_nxt == S_RUN && w_vs_edge)
        r_frame_cnt <= r_frame_cnt + 1'b1;
      if (w_fault_entry && r_fault_cnt != 8'hFF)
        r_fault_cnt <= r_fault_cnt + 1'b1;
    end
  end

  assign lnk.frame_cnt = r_frame_cnt;
  assign lnk.fault_cnt = r_fault_cnt;
`else
  assign lnk.frame_cnt = '0;
  assign lnk.fault_cnt = '0;
`endif

endmodule

// File: tb/tb_hdmi_link_ctrl.sv
// Scoreboard bench for hdmi_link_ctrl: stimulus queues expected state entries, a monitor
// pops one on every state change and checks the outputs that follow it.
module tb_hdmi_link_ctrl;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  hdmi_link_ctrl_if lnk();

  hdmi_link_ctrl #(
    .DEBOUNCE_CYCLES(4),
    .SETTLE_CYCLES(8),
    .VSYNC_TIMEOUT(50),
    .RETRY_CYCLES(10),
    .CNT_W(16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .lnk(lnk)
  );

`ifdef LINK_STATS_EN
  localparam int STATS = 1;
`else
  localparam int STATS = 0;
`endif

  typedef struct {
    logic [2:0] st;
    logic       trst;
    logic       ten;
    logic       lup;
    logic       flt;
  } exp_t;

  exp_t       q[$];
  exp_t       e;
  exp_t       pend;
  bit         pend_v = 1'b0;
  bit         mon_en = 1'b0;
  logic [2:0] prev = 3'd0;
  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  int         last_vs = 0;
  int         fault_pulses = 0;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic exp_t mk(input logic [2:0] s);
    exp_t r;
    r.st   = s;
    r.trst = !(s == 3'd3 || s == 3'd4);
    r.ten  = (s == 3'd4);
    r.lup  = (s == 3'd4);
    r.flt  = (s == 3'd5);
    return r;
  endfunction

  task automatic push(input logic [2:0] s);
    q.push_back(mk(s));
  endtask

  task automatic wait_state(input logic [2:0] s, input int budget, output int n);
    n = 0;
    while (lnk.state !== s && n < budget) begin
      @(negedge clk);
      n++;
    end
    check($sformatf("reach_state_%0d", s), {31'd0, lnk.state === s}, 32'd1);
  endtask

  task automatic vs_pulse();
    @(negedge clk);
    lnk.vsync = 1'b1;
    last_vs = cyc;
    repeat (2) @(negedge clk);
    lnk.vsync = 1'b0;
    repeat (28) @(negedge clk);
  endtask

  // Monitor: outputs lag the state by one cycle, fault coincides with FAULT entry.
  always @(negedge clk) begin
    if (mon_en) begin
      if (pend_v) begin
        check("tx_rst_after_entry", lnk.tx_rst, pend.trst);
        check("tx_en_after_entry", lnk.tx_en, pend.ten);
        check("link_up_after_entry", lnk.link_up, pend.lup);
        pend_v = 1'b0;
      end
      if (lnk.state !== prev) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_state: got %0d after %0d, none queued (cycle %0d)", lnk.state, prev, cyc);
        end else begin
          e = q.pop_front();
          check("state_entry", lnk.state, e.st);
          check("fault_on_entry", lnk.fault, e.flt);
          pend = e;
          pend_v = 1'b1;
        end
        prev = lnk.state;
      end else begin
        check("fault_idle", lnk.fault, 0);
      end
      if (lnk.fault === 1'b1) fault_pulses++;
    end
  end

  initial begin
    repeat (20000) @(posedge clk);
    errors++;
    $display("FAIL watchdog: got no finish expected finish within 20000 cycles");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "bench timeout");
  end

  initial begin
    int n;
    int cyc_f;
    int cyc_s;
    rst = 1'b1;
    lnk.hpd = 1'b0;
    lnk.pll_locked = 1'b0;
    lnk.vsync = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_state", lnk.state, 0);
    check("rst_tx_rst", lnk.tx_rst, 1);
    check("rst_tx_en", lnk.tx_en, 0);
    check("rst_link_up", lnk.link_up, 0);
    check("rst_fault", lnk.fault, 0);
    check("rst_frame_cnt", lnk.frame_cnt, 0);
    check("rst_fault_cnt", lnk.fault_cnt, 0);
    rst = 1'b0;
    mon_en = 1'b1;

    // HPD glitch shorter than the debounce window is ignored
    lnk.hpd = 1'b1;
    repeat (3) @(negedge clk);
    lnk.hpd = 1'b0;
    repeat (20) @(negedge clk);
    check("glitch_state", lnk.state, 0);
    push(3'd1);
    lnk.hpd = 1'b1;
    wait_state(3'd1, 30, n);
    repeat (5) @(negedge clk);
    check("wait_lock_hold", lnk.state, 1);

    // Normal bring-up
    push(3'd2);
    push(3'd3);
    lnk.pll_locked = 1'b1;
    wait_state(3'd2, 20, n);
    cyc_s = cyc;
    wait_state(3'd3, 20, n);
    check("settle_dwell", cyc - cyc_s, 8);
    push(3'd4);
    vs_pulse();
    check("run_tx_en", lnk.tx_en, 1);
    check("run_link_up", lnk.link_up, 1);
    repeat (5) vs_pulse();
    check("frame_cnt_5", lnk.frame_cnt, STATS ? 5 : 0);

    // vsync stall in RUN
    push(3'd5);
    push(3'd0);
    push(3'd1);
    push(3'd2);
    push(3'd3);
    wait_state(3'd5, 100, n);
    cyc_f = cyc;
    check("stall_latency", cyc_f - last_vs, 53);
    check("fault_cnt_1", lnk.fault_cnt, STATS ? 1 : 0);
    @(negedge clk);
    check("stall_tx_en", lnk.tx_en, 0);
    check("stall_tx_rst", lnk.tx_rst, 1);
    wait_state(3'd0, 20, n);
    check("retry_dwell", cyc - cyc_f, 10);
    wait_state(3'd3, 40, n);
    push(3'd4);
    vs_pulse();

    // Lock loss in RUN, then in SETTLE
    push(3'd5);
    push(3'd0);
    push(3'd1);
    lnk.pll_locked = 1'b0;
    wait_state(3'd5, 20, n);
    check("fault_cnt_2", lnk.fault_cnt, STATS ? 2 : 0);
    wait_state(3'd1, 40, n);
    repeat (3) @(negedge clk);
    check("lock_lost_hold", lnk.state, 1);
    push(3'd2);
    lnk.pll_locked = 1'b1;
    wait_state(3'd2, 20, n);
    push(3'd1);
    lnk.pll_locked = 1'b0;
    wait_state(3'd1, 20, n);
    @(negedge clk);
    check("settle_loss_tx_rst", lnk.tx_rst, 1);
    push(3'd2);
    push(3'd3);
    lnk.pll_locked = 1'b1;
    wait_state(3'd3, 40, n);
    push(3'd4);
    vs_pulse();

    // Hot unplug in RUN
    push(3'd0);
    lnk.hpd = 1'b0;
    wait_state(3'd0, 30, n);
    @(negedge clk);
    check("unplug_tx_en", lnk.tx_en, 0);
    check("unplug_fault_cnt", lnk.fault_cnt, STATS ? 2 : 0);

    // Replug, run, then synchronous reset mid-operation
    push(3'd1);
    push(3'd2);
    push(3'd3);
    lnk.hpd = 1'b1;
    wait_state(3'd3, 60, n);
    push(3'd4);
    vs_pulse();
    vs_pulse();
    check("frame_cnt_6", lnk.frame_cnt, STATS ? 6 : 0);
    push(3'd0);
    @(negedge clk);
    rst = 1'b1;
    lnk.hpd = 1'b0;
    lnk.pll_locked = 1'b0;
    @(negedge clk);
    check("midrst_state", lnk.state, 0);
    check("midrst_tx_en", lnk.tx_en, 0);
    check("midrst_tx_rst", lnk.tx_rst, 1);
    check("midrst_link_up", lnk.link_up, 0);
    check("midrst_frame_cnt", lnk.frame_cnt, 0);
    check("midrst_fault_cnt", lnk.fault_cnt, 0);
    rst = 1'b0;
    repeat (10) @(negedge clk);

    check("queue_drained", q.size(), 0);
    check("fault_pulse_total", fault_pulses, 2);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
